// File: rtl/ifu_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_ctrl_pkg
// Brief    : Shared types and constants for the instruction fetch controller
// Revision : 1.0 - initial release
// ============================================================================
package ifu_fetch_ctrl_pkg;

  // Fetch controller states: address phase, data phase, execute, fault
  typedef enum logic [1:0] {
    S_AR   = 2'd0,
    S_R    = 2'd1,
    S_EX   = 2'd2,
    S_HALT = 2'd3
  } state_t;

  localparam logic [1:0]  RESP_OKAY        = 2'b00;

  localparam logic [1:0]  CAUSE_NONE       = 2'b00;
  localparam logic [1:0]  CAUSE_BUS_ERR    = 2'b01;
  localparam logic [1:0]  CAUSE_MISALIGN   = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

endpackage : ifu_fetch_ctrl_pkg
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_ctrl_if
// Brief    : AXI-lite-style read channel (AR/R) between fetch unit and memory
// Revision : 1.0 - initial release
// ============================================================================
interface ifu_fetch_ctrl_if #(
  parameter int XLEN = 32
) ();

  logic            arvalid;
  logic            arready;
  logic [XLEN-1:0] araddr;
  logic            rvalid;
  logic            rready;
  logic [31:0]     rdata;
  logic [1:0]      rresp;

  // Fetch unit side: issues addresses, accepts data
  modport master (
    output arvalid, araddr, rready,
    input  arready, rvalid, rdata, rresp
  );

  // Instruction memory side
  modport slave (
    input  arvalid, araddr, rready,
    output arready, rvalid, rdata, rresp
  );

endinterface : ifu_fetch_ctrl_if
`default_nettype wire

// File: rtl/ifu_fetch_ctrl_pc_next_calc.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_ctrl_pc_next_calc
// Brief    : Combinational next-PC adder driven by the branch select pair
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl_pc_next_calc #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1,
  input  logic            pc_src_a,
  input  logic            pc_src_b,
  output logic [XLEN-1:0] next_pc,
  output logic            misaligned
);

  logic [XLEN-1:0] add_a;
  logic [XLEN-1:0] add_b;
  logic [XLEN-1:0] sum;

  assign add_a = pc_src_a ? imm : XLEN'(4);
  assign add_b = pc_src_b ? rs1 : pc;
  // Wrap-around past the top of the address space is intentionally silent
  assign sum   = add_a + add_b;

  // jalr drops bit 0 of the target; every other form uses the raw sum
  assign next_pc    = (pc_src_a && pc_src_b) ? {sum[XLEN-1:1], 1'b0} : sum;
  assign misaligned = |next_pc[1:0];

endmodule : ifu_fetch_ctrl_pc_next_calc
`default_nettype wire

// File: rtl/ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ifu_fetch_ctrl
// Brief    : Multi-cycle fetch unit: owns the PC, fetches over AR/R, holds
//            the instruction until commit, then advances to the next PC
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch_ctrl
  import ifu_fetch_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_src_a,
  input  logic                pc_src_b,
  input  logic [XLEN-1:0]     imm,
  input  logic [XLEN-1:0]     rs1,
  input  logic                exec_done,
  ifu_fetch_ctrl_if.master    bus,
  output logic                inst_valid,
  output logic [31:0]         inst,
  output logic [XLEN-1:0]     pc,
  output logic                halt,
  output logic [1:0]          halt_cause
);

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [31:0]     inst_nxt;
  logic            inst_valid_nxt;
  logic            halt_nxt;
  logic [1:0]      halt_cause_nxt;
  logic            arvalid_st;
  logic            rready_st;
  logic [XLEN-1:0] calc_pc;
  logic            calc_misaligned;

  ifu_fetch_ctrl_pc_next_calc #(
    .XLEN (XLEN)
  ) u_pc_next_calc (
    .pc         (pc),
    .imm        (imm),
    .rs1        (rs1),
    .pc_src_a   (pc_src_a),
    .pc_src_b   (pc_src_b),
    .next_pc    (calc_pc),
    .misaligned (calc_misaligned)
  );

  // Handshake outputs are masked during reset so no transfer can start
  // in a cycle whose state is about to be discarded
  assign bus.arvalid = arvalid_st && !rst;
  assign bus.rready  = rready_st && !rst;
  assign bus.araddr  = pc;

  // Next-state and handshake decode for the fetch/execute sequence
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    inst_nxt       = inst;
    inst_valid_nxt = inst_valid;
    halt_nxt       = halt;
    halt_cause_nxt = halt_cause;
    arvalid_st     = 1'b0;
    rready_st      = 1'b0;
    case (state)
      S_AR: begin
        arvalid_st = 1'b1;
        if (bus.arready) begin
          state_nxt = S_R;
        end
      end
      S_R: begin
        rready_st = 1'b1;
        if (bus.rvalid) begin
          if (bus.rresp == RESP_OKAY) begin
            inst_nxt       = bus.rdata;
            inst_valid_nxt = 1'b1;
            state_nxt      = S_EX;
          end else begin
            halt_nxt       = 1'b1;
            halt_cause_nxt = CAUSE_BUS_ERR;
            state_nxt      = S_HALT;
          end
        end
      end
      S_EX: begin
        if (exec_done) begin
          inst_valid_nxt = 1'b0;
          if (calc_misaligned) begin
            halt_nxt       = 1'b1;
            halt_cause_nxt = CAUSE_MISALIGN;
            state_nxt      = S_HALT;
          end else begin
            pc_nxt    = calc_pc;
            state_nxt = S_AR;
          end
        end
      end
      S_HALT: begin
        inst_valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = S_AR;
      end
    endcase
  end

  // State and architectural registers, reset synchronously
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_AR;
      pc         <= RESET_PC;
      inst       <= 32'd0;
      inst_valid <= 1'b0;
      halt       <= 1'b0;
      halt_cause <= CAUSE_NONE;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      inst       <= inst_nxt;
      inst_valid <= inst_valid_nxt;
      halt       <= halt_nxt;
      halt_cause <= halt_cause_nxt;
    end
  end

endmodule : ifu_fetch_ctrl
`default_nettype wire

// File: tb/tb_ifu_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_ifu_fetch_ctrl
// Brief    : Self-checking bench for ifu_fetch_ctrl with a behavioural model
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_src_a, pc_src_b, exec_done;
  logic [31:0] imm, rs1;
  logic        inst_valid, halt;
  logic [31:0] inst, pc;
  logic [1:0]  halt_cause;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  ifu_fetch_ctrl_if #(.XLEN(32)) bus ();

  ifu_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_src_a   (pc_src_a),
    .pc_src_b   (pc_src_b),
    .imm        (imm),
    .rs1        (rs1),
    .exec_done  (exec_done),
    .bus        (bus),
    .inst_valid (inst_valid),
    .inst       (inst),
    .pc         (pc),
    .halt       (halt),
    .halt_cause (halt_cause)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // phase: 0 waiting for address accept, 1 waiting for data,
  //        2 instruction held for execute, 3 faulted
  int          m_phase;
  logic [31:0] m_pc, m_inst;
  logic        m_iv, m_halt;
  logic [1:0]  m_cause;

  function automatic logic [31:0] target(input logic sa, input logic sb,
                                         input logic [31:0] im, input logic [31:0] r,
                                         input logic [31:0] p);
    logic [31:0] t;
    t = (sa ? im : 32'd4) + (sb ? r : p);
    if (sa && sb) t = t & 32'hFFFF_FFFE;
    return t;
  endfunction

  always @(posedge clk) begin
    logic [31:0] t;
    if (rst) begin
      m_phase = 0; m_pc = RST_PC; m_inst = 0; m_iv = 0; m_halt = 0; m_cause = 0;
    end else begin
      case (m_phase)
        0: if (bus.arready) m_phase = 1;
        1: if (bus.rvalid) begin
             if (bus.rresp == 2'b00) begin
               m_inst = bus.rdata; m_iv = 1; m_phase = 2;
             end else begin
               m_halt = 1; m_cause = 2'd1; m_phase = 3;
             end
           end
        2: if (exec_done) begin
             t = target(pc_src_a, pc_src_b, imm, rs1, m_pc);
             m_iv = 0;
             if (t % 4 != 0) begin
               m_halt = 1; m_cause = 2'd2; m_phase = 3;
             end else begin
               m_pc = t; m_phase = 0;
             end
           end
        default: ;
      endcase
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every DUT output against the model
  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_arvalid", 64'(bus.arvalid), 64'((m_phase == 0) && !rst));
      if (m_phase == 0 && !rst) check("cyc_araddr", 64'(bus.araddr), 64'(m_pc));
      check("cyc_rready", 64'(bus.rready), 64'((m_phase == 1) && !rst));
      check("cyc_inst_valid", 64'(inst_valid), 64'(m_iv));
      check("cyc_inst", 64'(inst), 64'(m_inst));
      check("cyc_pc", 64'(pc), 64'(m_pc));
      check("cyc_halt", 64'(halt), 64'(m_halt));
      check("cyc_halt_cause", 64'(halt_cause), 64'(m_cause));
    end
  end

  // ---------------- stimulus helpers ----------------
  // Inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch(input logic [31:0] d);
    bus.arready = 1; step();
    bus.arready = 0; bus.rvalid = 1; bus.rresp = 2'b00; bus.rdata = d; step();
    bus.rvalid = 0;
  endtask

  task automatic do_exec(input logic sa, input logic sb, input logic [31:0] im,
                         input logic [31:0] r);
    pc_src_a = sa; pc_src_b = sb; imm = im; rs1 = r; exec_done = 1; step();
    exec_done = 0;
  endtask

  initial begin
    rst = 1; pc_src_a = 0; pc_src_b = 0; imm = 0; rs1 = 0; exec_done = 0;
    bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    step();
    chk_en = 1;
    step();
    check("reset_arvalid_low", 64'(bus.arvalid), 64'd0);
    check("reset_pc", 64'(pc), 64'h8000_0000);
    check("reset_inst", 64'(inst), 64'd0);
    check("reset_halt_cause", 64'(halt_cause), 64'd0);
    rst = 0; #1;
    check("first_arvalid", 64'(bus.arvalid), 64'd1);
    check("first_araddr", 64'(bus.araddr), 64'h8000_0000);

    fetch(32'h0000_0013);
    check("fetch_inst_valid", 64'(inst_valid), 64'd1);
    check("fetch_inst", 64'(inst), 64'h13);
    do_exec(0, 0, 32'h0, 32'h0);
    check("seq_arvalid", 64'(bus.arvalid), 64'd1);
    check("seq_araddr", 64'(bus.araddr), 64'h8000_0004);

    fetch(32'h0000_0013); do_exec(1, 0, 32'h0000_000C, 32'h0);
    check("branch_to_10", 64'(pc), 64'h8000_0010);
    fetch(32'h0000_0013); do_exec(1, 0, 32'hFFFF_FFF0, 32'h0);
    check("branch_back", 64'(pc), 64'h8000_0000);
    fetch(32'h0000_0013); do_exec(1, 1, 32'h0000_0003, 32'h8000_0101);
    check("jalr_target", 64'(pc), 64'h8000_0104);

    // Address stall with a spurious data beat
    bus.arready = 0; bus.rvalid = 1; bus.rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_arvalid", 64'(bus.arvalid), 64'd1);
      check("stall_araddr", 64'(bus.araddr), 64'h8000_0104);
      check("stall_inst_valid", 64'(inst_valid), 64'd0);
    end
    bus.rvalid = 0;
    fetch(32'h0000_0013);
    do_exec(0, 0, 32'h0, 32'h0);

    // Bus error
    bus.arready = 1; step();
    bus.arready = 0; bus.rvalid = 1; bus.rresp = 2'b10; step();
    bus.rvalid = 0; bus.rresp = 2'b00;
    check("buserr_halt", 64'(halt), 64'd1);
    check("buserr_cause", 64'(halt_cause), 64'd1);
    bus.arready = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("halted_arvalid", 64'(bus.arvalid), 64'd0);
    end
    bus.arready = 0;
    rst = 1; step(); rst = 0;
    check("recover_pc", 64'(pc), 64'h8000_0000);
    check("recover_halt", 64'(halt), 64'd0);

    // Misaligned branch target
    fetch(32'h0000_0013); do_exec(1, 0, 32'h0000_0002, 32'h0);
    check("misalign_cause", 64'(halt_cause), 64'd2);
    check("misalign_pc", 64'(pc), 64'h8000_0000);
    check("misalign_inst_valid", 64'(inst_valid), 64'd0);

    // Reset while waiting for data; the late beat must be ignored
    rst = 1; step(); rst = 0;
    bus.arready = 1; step(); bus.arready = 0;
    rst = 1; bus.rvalid = 1; bus.rdata = 32'h55; step(); rst = 0; #1;
    check("rst_in_r_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_in_r_arvalid", 64'(bus.arvalid), 64'd1);
    check("rst_in_r_rready", 64'(bus.rready), 64'd0);
    step();
    check("late_rvalid_ignored", 64'(inst_valid), 64'd0);
    bus.rvalid = 0;

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      bus.arready = ($urandom % 3) != 0;
      bus.rvalid  = ($urandom % 3) != 0;
      bus.rdata   = $urandom;
      bus.rresp   = (($urandom % 25) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      exec_done   = ($urandom % 3) == 0;
      pc_src_a    = $urandom % 2;
      pc_src_b    = ($urandom % 4) == 0;
      imm         = (($urandom % 10) == 0) ? $urandom : ($urandom & 32'h0000_0FFC);
      rs1         = (($urandom % 10) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
      if (m_halt) rst = ($urandom % 6) == 0;
      else        rst = ($urandom % 300) == 0;
      step();
    end
    rst = 0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_ifu_fetch_ctrl
`default_nettype wire

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
- Multi-cycle instruction fetch unit: owns the architectural PC and turns the branch controller's pc_src_a/pc_src_b decision into the next fetch address.
- Fetches over an AXI-lite-style read channel (AR/R), presents the instruction to decode/execute, waits for commit, then advances the PC.
- Sits between the branch-condition logic (upstream select encoding) and instruction memory.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h8000_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- pc_src_a  in  1  adder input A select: 0 = constant 4, 1 = imm.
- pc_src_b  in  1  adder input B select: 0 = current PC, 1 = rs1.
- imm  in  XLEN  immediate from decode.
- rs1  in  XLEN  rs1 read data.
- exec_done  in  1  current instruction committed; selects are valid this cycle.
- arvalid  out  1  read address valid.
- arready  in  1  read address ready.
- araddr  out  XLEN  fetch address; equals pc.
- rvalid  in  1  read data valid.
- rready  out  1  read data ready.
- rdata  in  32  fetched instruction.
- rresp  in  2  response; 2'b00 = OKAY, any other value = error.
- inst_valid  out  1  inst holds a fetched, uncommitted instruction.
- inst  out  32  current instruction.
- pc  out  XLEN  PC of the instruction being fetched or executed.
- halt  out  1  sticky fault indicator.
- halt_cause  out  2  00 none, 01 bus error, 10 misaligned target.

Behaviour:
- Reset values: pc=RESET_PC; state=S_AR; arvalid=0 in the reset cycle; rready=0, inst_valid=0, inst=0, halt=0, halt_cause=00.
- Reset mid-operation abandons any outstanding transaction. An rvalid arriving after reset is ignored until a new AR handshake completes.
- S_AR:
  - arvalid=1, araddr=pc.
  - arvalid stays high and araddr stays stable until arready is sampled high.
  - On arvalid&&arready go to S_R.
- S_R:
  - rready=1. rvalid is ignored in every other state.
  - On rvalid with rresp==00: inst<=rdata, inst_valid<=1, go to S_EX.
  - On rvalid with rresp!=00: halt<=1, halt_cause<=01, go to S_HALT.
- S_EX:
  - inst_valid=1; inst and pc stable.
  - On exec_done, compute next_pc:
    - a = pc_src_a ? imm : 4.
    - b = pc_src_b ? rs1 : pc.
    - sum = a+b, modulo 2^XLEN; wrap-around is silent.
    - If pc_src_a&&pc_src_b (jalr), next_pc = sum & ~1; otherwise next_pc = sum.
  - If next_pc[1:0]!=0: halt<=1, halt_cause<=10, pc unchanged, go to S_HALT.
  - Otherwise: pc<=next_pc, inst_valid<=0, go to S_AR.
- S_HALT:
  - All handshake outputs 0; inst_valid=0.
  - Only rst leaves this state.
- exec_done outside S_EX is ignored.
- Selects are sampled only in the exec_done cycle.
- Latency: one cycle from exec_done to arvalid for the new PC. With zero-wait memory, one instruction takes 3 cycles plus execute time.
- Select encoding: (0,0) seq, (1,0) pc+imm branch/jal, (1,1) jalr, (0,1) rs1+4. The (0,1) case is never produced upstream but is computed as specified.

Decomposition:
- Shared package:
  - state enum: S_AR, S_R, S_EX, S_HALT.
  - RESP_OKAY = 2'b00.
  - halt_cause codes.
  - RESET_PC default.
- One natural sub-module: pc_next_calc, combinational. Inputs: pc, imm, rs1, pc_src_a, pc_src_b. Outputs: next_pc, misaligned. Reused by any future pipelined front end.
- The FSM and registers stay in ifu_fetch_ctrl.

Test Plan:
- Reset then arready=1, rvalid one cycle later with rdata=32'h00000013 -> araddr=0x80000000, inst_valid=1, inst=0x00000013; exec_done with selects 00 -> next araddr=0x80000004.
- In S_EX with pc=0x80000010, pc_src_a=1, pc_src_b=0, imm=0xFFFFFFF0, exec_done -> pc=0x80000000.
- jalr: pc_src_a=1, pc_src_b=1, rs1=0x80000101, imm=0x3 -> pc=0x80000104 (bit0 cleared).
- arready held low 5 cycles -> arvalid stays 1 and araddr constant; a spurious rvalid during that time is ignored.
- rresp=2'b10 -> halt=1, halt_cause=01, arvalid stays 0 forever; rst -> pc=0x80000000, fetch resumes.
- Branch target imm=0x2 from pc=0x80000000 -> halt_cause=10, pc remains 0x80000000. Also: rst asserted while in S_R -> next cycle state S_AR, inst_valid=0.
